// File: rtl/eth_idma_desc_queue.sv
// ----------------------------------------------------------------------------
// eth_idma_desc_queue
//
// Descriptor queue and issue stage in front of the iDMA backend. Descriptors
// pushed by software or a register bank are buffered in a FIFO, then issued
// to the backend while the number of in-flight transfers stays below
// MaxOutstanding. Backend responses are retired, counted (completions and
// errors) and signalled to the interrupt logic as a one-cycle pulse.
//
// Optional feature macro: ETH_IDMA_DESC_ERR_CNT_EN
//   defined   : err_cnt_o counts errored responses and dropped zero-length
//               descriptors.
//   undefined : err_cnt_o is tied to 0, no counter is built and rsp_error_i
//               is ignored. Zero-length descriptors are still dropped.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous flush of queue and counters
//   desc_valid_i/ready_o     descriptor push handshake
//   desc_*_i                 descriptor fields (addresses, length, protocols)
//   req_valid_o/ready_i      backend request handshake
//   req_*_o                  head-of-queue descriptor fields
//   rsp_valid_i/ready_o      backend response handshake
//   rsp_error_i              response carries an error
//   fill_o                   FIFO occupancy
//   outstanding_o            issued transfers awaiting a response
//   done_cnt_o, err_cnt_o    saturating completion / error counters
//   busy_o                   queue non-empty or transfers in flight
//   irq_o                    one-cycle pulse per retired response
// ----------------------------------------------------------------------------
module eth_idma_desc_queue #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned TFLenWidth     = 32,
    parameter int unsigned NumDesc        = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned ProtWidth      = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,

    input  logic                                 desc_valid_i,
    output logic                                 desc_ready_o,
    input  logic [AddrWidth-1:0]                 desc_src_addr_i,
    input  logic [AddrWidth-1:0]                 desc_dst_addr_i,
    input  logic [TFLenWidth-1:0]                desc_length_i,
    input  logic [ProtWidth-1:0]                 desc_src_protocol_i,
    input  logic [ProtWidth-1:0]                 desc_dst_protocol_i,

    output logic                                 req_valid_o,
    input  logic                                 req_ready_i,
    output logic [AddrWidth-1:0]                 req_src_addr_o,
    output logic [AddrWidth-1:0]                 req_dst_addr_o,
    output logic [TFLenWidth-1:0]                req_length_o,
    output logic [ProtWidth-1:0]                 req_src_protocol_o,
    output logic [ProtWidth-1:0]                 req_dst_protocol_o,

    input  logic                                 rsp_valid_i,
    output logic                                 rsp_ready_o,
    input  logic                                 rsp_error_i,

    output logic [$clog2(NumDesc):0]             fill_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic [15:0]                          done_cnt_o,
    output logic [15:0]                          err_cnt_o,
    output logic                                 busy_o,
    output logic                                 irq_o
);

    localparam int unsigned IdxW = $clog2(NumDesc);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    // Saturating add of a small increment (0..2) to a 16-bit counter.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Descriptor storage
    logic [AddrWidth-1:0]  src_mem   [NumDesc];
    logic [AddrWidth-1:0]  dst_mem   [NumDesc];
    logic [TFLenWidth-1:0] len_mem   [NumDesc];
    logic [ProtWidth-1:0]  sprot_mem [NumDesc];
    logic [ProtWidth-1:0]  dprot_mem [NumDesc];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OutW-1:0] outstanding_q;
    logic [15:0]     done_cnt_q;
    logic            irq_q;

    logic full, empty;
    logic push, store, drop, issue, retire;
    logic [IdxW-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];

    // Extra pointer MSB distinguishes full (wrapped once) from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) && (wr_idx == rd_idx);

    assign desc_ready_o = !full && !clear_i;
    assign push         = desc_valid_i && desc_ready_o;
    assign store        = push && (desc_length_i != '0);
    assign drop         = push && (desc_length_i == '0);

    // Only registered state and clear_i feed the valid/ready outputs, so the
    // request stays stable until accepted: pushes never touch the head and
    // responses only lower the outstanding count.
    assign req_valid_o = !empty && (outstanding_q < MaxOut) && !clear_i;
    assign issue       = req_valid_o && req_ready_i;

    assign rsp_ready_o = (outstanding_q != '0);
    assign retire      = rsp_valid_i && rsp_ready_o;

    assign req_src_addr_o     = src_mem[rd_idx];
    assign req_dst_addr_o     = dst_mem[rd_idx];
    assign req_length_o       = len_mem[rd_idx];
    assign req_src_protocol_o = sprot_mem[rd_idx];
    assign req_dst_protocol_o = dprot_mem[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumDesc; i++) begin
                src_mem[i]   <= '0;
                dst_mem[i]   <= '0;
                len_mem[i]   <= '0;
                sprot_mem[i] <= '0;
                dprot_mem[i] <= '0;
            end
        end else if (store) begin
            src_mem[wr_idx]   <= desc_src_addr_i;
            dst_mem[wr_idx]   <= desc_dst_addr_i;
            len_mem[wr_idx]   <= desc_length_i;
            sprot_mem[wr_idx] <= desc_src_protocol_i;
            dprot_mem[wr_idx] <= desc_dst_protocol_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (store) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (issue) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Not flushed by clear_i: transfers already handed to the backend still
    // come back and must be retired.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   outstanding_q <= outstanding_q + OutW'(1);
                2'b01:   outstanding_q <= outstanding_q - OutW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // A response retiring in the clear cycle is still counted afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_cnt_q <= '0;
        end else if (clear_i) begin
            done_cnt_q <= {15'b0, retire};
        end else if (retire) begin
            done_cnt_q <= sat_add(done_cnt_q, 2'd1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= retire;
    end

`ifdef ETH_IDMA_DESC_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic [1:0]  err_inc;

    // A dropped descriptor and an errored response can coincide: +2.
    assign err_inc = {1'b0, drop} + {1'b0, retire && rsp_error_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (clear_i) begin
            err_cnt_q <= {15'b0, retire && rsp_error_i};
        end else if (err_inc != 2'd0) begin
            err_cnt_q <= sat_add(err_cnt_q, err_inc);
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err;
    assign unused_err = rsp_error_i ^ drop;
    assign err_cnt_o  = '0;
`endif

    assign fill_o        = wr_ptr_q - rd_ptr_q;
    assign outstanding_o = outstanding_q;
    assign done_cnt_o    = done_cnt_q;
    assign busy_o        = (wr_ptr_q != rd_ptr_q) || (outstanding_q != '0);
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_eth_idma_desc_queue.sv
module tb_eth_idma_desc_queue;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [31:0] desc_src_addr_i, desc_dst_addr_i, desc_length_i;
    logic [2:0]  desc_src_protocol_i, desc_dst_protocol_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_src_addr_o, req_dst_addr_o, req_length_o;
    logic [2:0]  req_src_protocol_o, req_dst_protocol_o;
    logic        rsp_valid_i, rsp_ready_o, rsp_error_i;
    logic [2:0]  fill_o;
    logic [1:0]  outstanding_o;
    logic [15:0] done_cnt_o, err_cnt_o;
    logic        busy_o, irq_o;

`ifdef ETH_IDMA_DESC_ERR_CNT_EN
    localparam int ErrEn = 1;
`else
    localparam int ErrEn = 0;
`endif

    always #5 clk = ~clk;

    eth_idma_desc_queue #(
        .AddrWidth(32), .TFLenWidth(32), .NumDesc(4), .MaxOutstanding(2), .ProtWidth(3)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
        .desc_length_i(desc_length_i),
        .desc_src_protocol_i(desc_src_protocol_i), .desc_dst_protocol_i(desc_dst_protocol_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_src_addr_o(req_src_addr_o), .req_dst_addr_o(req_dst_addr_o),
        .req_length_o(req_length_o),
        .req_src_protocol_o(req_src_protocol_o), .req_dst_protocol_o(req_dst_protocol_o),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
        .fill_o(fill_o), .outstanding_o(outstanding_o),
        .done_cnt_o(done_cnt_o), .err_cnt_o(err_cnt_o),
        .busy_o(busy_o), .irq_o(irq_o)
    );

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [2:0]  sp;
        logic [2:0]  dp;
    } desc_t;

    desc_t sb_q[$];
    desc_t exp_d, got_d;
    int    total  = 0;
    int    passed = 0;
    bit    sb_en  = 1'b1;
    logic  irq_exp = 1'b0;

    // Scoreboard: every accepted request must match the oldest queued
    // descriptor; irq_o must pulse exactly one cycle after each response.
    always @(negedge clk) begin
        if (sb_en && req_valid_o && req_ready_i) begin
            total++;
            got_d = {req_src_addr_o, req_dst_addr_o, req_length_o, req_src_protocol_o, req_dst_protocol_o};
            if (sb_q.size() == 0) begin
                $display("FAIL sb_issue: unexpected request %h, required no request", got_d);
            end else begin
                exp_d = sb_q.pop_front();
                if (got_d !== exp_d) $display("FAIL sb_issue: got %h required %h", got_d, exp_d);
                else passed++;
            end
        end
        if (sb_en && (irq_exp || irq_o)) begin
            total++;
            if (irq_o !== irq_exp) $display("FAIL sb_irq: irq_o=%b required %b", irq_o, irq_exp);
            else passed++;
        end
        irq_exp = rst_ni && rsp_valid_i && rsp_ready_o;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input logic [2:0] sp, input logic [2:0] dp);
        bit ok;
        ok = 1'b0;
        desc_src_addr_i = s; desc_dst_addr_i = d; desc_length_i = l;
        desc_src_protocol_i = sp; desc_dst_protocol_i = dp;
        desc_valid_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (desc_ready_o) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) $display("FAIL push_timeout: desc_ready_o=%b required 1", desc_ready_o);
        else passed++;
        if (ok && l != 0) sb_q.push_back({s, d, l, sp, dp});
        cyc();
        desc_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_ready_i = 1'b1; rsp_valid_i = 1'b1; rsp_error_i = 1'b0;
        @(negedge clk);
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy_o !== 1'b0) $display("FAIL drain_timeout: busy_o=%b required 0", busy_o);
        else passed++;
        cyc();
        req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        sb_q.delete();
        cyc();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; desc_valid_i = 1'b0;
        desc_src_addr_i = '0; desc_dst_addr_i = '0; desc_length_i = '0;
        desc_src_protocol_i = '0; desc_dst_protocol_i = '0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_error_i = 1'b0;
        repeat (3) cyc();
        rst_ni = 1'b1;
        @(negedge clk);
        total++; if (desc_ready_o !== 1'b1) $display("FAIL rst_desc_ready: got %b required 1", desc_ready_o); else passed++;
        total++; if (req_valid_o !== 1'b0) $display("FAIL rst_req_valid: got %b required 0", req_valid_o); else passed++;
        total++; if (rsp_ready_o !== 1'b0) $display("FAIL rst_rsp_ready: got %b required 0", rsp_ready_o); else passed++;
        total++; if ({irq_o, busy_o} !== 2'b00) $display("FAIL rst_irq_busy: got %b required 00", {irq_o, busy_o}); else passed++;
        total++; if ({fill_o, outstanding_o, done_cnt_o, err_cnt_o} !== '0)
            $display("FAIL rst_counts: fill=%0d out=%0d done=%0d err=%0d required all 0", fill_o, outstanding_o, done_cnt_o, err_cnt_o);
        else passed++;
        total++; if ({req_src_addr_o, req_dst_addr_o, req_length_o} !== '0)
            $display("FAIL rst_req_data: got %h/%h/%h required 0", req_src_addr_o, req_dst_addr_o, req_length_o);
        else passed++;
        cyc();
    endtask

    task automatic test_basic();
        req_ready_i = 1'b1;
        push(32'h1000, 32'h2000, 32'd64, 3'd1, 3'd2);
        @(negedge clk);
        total++; if (req_valid_o !== 1'b1) $display("FAIL basic_req_valid: got %b required 1", req_valid_o); else passed++;
        total++; if (req_src_addr_o !== 32'h1000 || req_dst_addr_o !== 32'h2000 || req_length_o !== 32'd64)
            $display("FAIL basic_fields: got %h/%h/%0d required 1000/2000/64", req_src_addr_o, req_dst_addr_o, req_length_o);
        else passed++;
        cyc();
        @(negedge clk);
        total++; if (outstanding_o !== 2'd1) $display("FAIL basic_outstanding: got %0d required 1", outstanding_o); else passed++;
        total++; if (rsp_ready_o !== 1'b1) $display("FAIL basic_rsp_ready: got %b required 1", rsp_ready_o); else passed++;
        cyc();
        rsp_valid_i = 1'b1;
        cyc();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        total++; if (done_cnt_o !== 16'd1) $display("FAIL basic_done: got %0d required 1", done_cnt_o); else passed++;
        total++; if (irq_o !== 1'b1) $display("FAIL basic_irq: got %b required 1", irq_o); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL basic_busy: got %b required 0", busy_o); else passed++;
        cyc();
        @(negedge clk);
        total++; if (irq_o !== 1'b0) $display("FAIL basic_irq_pulse: got %b required 0", irq_o); else passed++;
        cyc();
        req_ready_i = 1'b0;
    endtask

    task automatic test_full();
        req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'hA000 + 32'(i), 32'hB000 + 32'(i), 32'd16 + 32'(i), 3'(i), 3'(i + 1));
        @(negedge clk);
        total++; if (fill_o !== 3'd4) $display("FAIL full_fill: got %0d required 4", fill_o); else passed++;
        cyc();
        desc_src_addr_i = 32'hA004; desc_dst_addr_i = 32'hB004; desc_length_i = 32'd20;
        desc_src_protocol_i = 3'd4; desc_dst_protocol_i = 3'd5;
        desc_valid_i = 1'b1; req_ready_i = 1'b1;
        @(negedge clk);
        total++; if (desc_ready_o !== 1'b0) $display("FAIL full_ready_low: got %b required 0", desc_ready_o); else passed++;
        cyc();
        req_ready_i = 1'b0;
        @(negedge clk);
        total++; if (desc_ready_o !== 1'b1) $display("FAIL full_ready_high: got %b required 1", desc_ready_o); else passed++;
        sb_q.push_back({32'hA004, 32'hB004, 32'd20, 3'd4, 3'd5});
        cyc();
        desc_valid_i = 1'b0;
        @(negedge clk);
        total++; if (fill_o !== 3'd4) $display("FAIL full_fifth_accepted: fill=%0d required 4", fill_o); else passed++;
        cyc();
        drain();
    endtask

    task automatic test_limit();
        do_clear();
        req_ready_i = 1'b1; rsp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++)
            push(32'hC000 + 32'(i), 32'hD000 + 32'(i), 32'd100 + 32'(i), 3'd2, 3'd3);
        cyc();
        @(negedge clk);
        total++; if (outstanding_o !== 2'd2) $display("FAIL limit_outstanding: got %0d required 2", outstanding_o); else passed++;
        total++; if (req_valid_o !== 1'b0) $display("FAIL limit_req_valid: got %b required 0", req_valid_o); else passed++;
        total++; if (fill_o !== 3'd1) $display("FAIL limit_fill: got %0d required 1", fill_o); else passed++;
        cyc();
        rsp_valid_i = 1'b1;
        cyc();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        total++; if (req_valid_o !== 1'b1) $display("FAIL limit_reissue: req_valid=%b required 1", req_valid_o); else passed++;
        cyc();
        @(negedge clk);
        total++; if (outstanding_o !== 2'd2 || fill_o !== 3'd0)
            $display("FAIL limit_third: out=%0d fill=%0d required 2/0", outstanding_o, fill_o);
        else passed++;
        cyc();
        drain();
    endtask

    task automatic test_errors();
        do_clear();
        req_ready_i = 1'b1; rsp_valid_i = 1'b0;
        push(32'hE000, 32'hF000, 32'd0, 3'd0, 3'd0);
        @(negedge clk);
        total++; if (fill_o !== 3'd0) $display("FAIL err_drop_fill: got %0d required 0", fill_o); else passed++;
        total++; if (err_cnt_o !== 16'(ErrEn)) $display("FAIL err_drop_cnt: got %0d required %0d", err_cnt_o, ErrEn); else passed++;
        cyc();
        push(32'hE100, 32'hF100, 32'd8, 3'd1, 3'd1);
        push(32'hE200, 32'hF200, 32'd8, 3'd1, 3'd1);
        @(negedge clk);
        total++; if (fill_o > 3'd1) $display("FAIL err_fill_max: got %0d required <=1", fill_o); else passed++;
        cyc();
        rsp_valid_i = 1'b1; rsp_error_i = 1'b1;
        cyc();
        rsp_error_i = 1'b0;
        cyc();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        total++; if (done_cnt_o !== 16'd2) $display("FAIL err_done: got %0d required 2", done_cnt_o); else passed++;
        total++; if (err_cnt_o !== 16'(2 * ErrEn)) $display("FAIL err_cnt: got %0d required %0d", err_cnt_o, 2 * ErrEn); else passed++;
        cyc();
        push(32'hE300, 32'hF300, 32'd4, 3'd2, 3'd2);
        cyc();
        cyc();
        desc_length_i = 32'd0; desc_valid_i = 1'b1;
        rsp_valid_i = 1'b1; rsp_error_i = 1'b1;
        cyc();
        desc_valid_i = 1'b0; rsp_valid_i = 1'b0; rsp_error_i = 1'b0;
        @(negedge clk);
        total++; if (err_cnt_o !== 16'(4 * ErrEn)) $display("FAIL err_double: got %0d required %0d", err_cnt_o, 4 * ErrEn); else passed++;
        total++; if (done_cnt_o !== 16'd3 || fill_o !== 3'd0)
            $display("FAIL err_double_done: done=%0d fill=%0d required 3/0", done_cnt_o, fill_o);
        else passed++;
        cyc();
        req_ready_i = 1'b0;
    endtask

    task automatic test_clear();
        req_ready_i = 1'b1; rsp_valid_i = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h5000 + 32'(i), 32'h6000 + 32'(i), 32'd32, 3'd3, 3'd4);
        @(negedge clk);
        total++; if (outstanding_o !== 2'd2 || fill_o !== 3'd2)
            $display("FAIL clr_setup: out=%0d fill=%0d required 2/2", outstanding_o, fill_o);
        else passed++;
        cyc();
        do_clear();
        @(negedge clk);
        total++; if (fill_o !== 3'd0) $display("FAIL clr_fill: got %0d required 0", fill_o); else passed++;
        total++; if (done_cnt_o !== 16'd0 || err_cnt_o !== 16'd0)
            $display("FAIL clr_counts: done=%0d err=%0d required 0/0", done_cnt_o, err_cnt_o);
        else passed++;
        total++; if (outstanding_o !== 2'd2) $display("FAIL clr_outstanding: got %0d required 2", outstanding_o); else passed++;
        total++; if (busy_o !== 1'b1) $display("FAIL clr_busy: got %b required 1", busy_o); else passed++;
        cyc();
        rsp_valid_i = 1'b1;
        cyc();
        cyc();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        total++; if (done_cnt_o !== 16'd2) $display("FAIL clr_done: got %0d required 2", done_cnt_o); else passed++;
        total++; if (busy_o !== 1'b0 || outstanding_o !== 2'd0)
            $display("FAIL clr_idle: busy=%b out=%0d required 0/0", busy_o, outstanding_o);
        else passed++;
        cyc();
        req_ready_i = 1'b0;
    endtask

    task automatic test_saturation();
        int nrsp;
        nrsp = 0;
        sb_en = 1'b0;
        do_clear();
        desc_src_addr_i = 32'h7000; desc_dst_addr_i = 32'h8000; desc_length_i = 32'd4;
        desc_valid_i = 1'b1; req_ready_i = 1'b1; rsp_valid_i = 1'b1; rsp_error_i = 1'b0;
        for (int n = 0; n < 70000 && nrsp < 65536; n++) begin
            @(negedge clk);
            if (rsp_valid_i && rsp_ready_o) nrsp++;
        end
        cyc();
        desc_valid_i = 1'b0;
        total++; if (nrsp != 65536) $display("FAIL sat_timeout: responses=%0d required 65536", nrsp); else passed++;
        drain();
        @(negedge clk);
        total++; if (done_cnt_o !== 16'hFFFF) $display("FAIL sat_done: got %h required ffff", done_cnt_o); else passed++;
        total++; if (err_cnt_o !== 16'd0) $display("FAIL sat_err: got %0d required 0", err_cnt_o); else passed++;
        cyc();
        sb_q.delete();
        sb_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        req_ready_i = 1'b0;
        push(32'h9000, 32'h9100, 32'd12, 3'd5, 3'd6);
        push(32'h9200, 32'h9300, 32'd12, 3'd5, 3'd6);
        #2;
        rst_ni = 1'b0;
        #1;
        total++; if (fill_o !== 3'd0 || busy_o !== 1'b0 || req_valid_o !== 1'b0)
            $display("FAIL rstmid_state: fill=%0d busy=%b req_valid=%b required 0/0/0", fill_o, busy_o, req_valid_o);
        else passed++;
        total++; if (req_src_addr_o !== 32'h0 || done_cnt_o !== 16'd0)
            $display("FAIL rstmid_data: src=%h done=%0d required 0/0", req_src_addr_o, done_cnt_o);
        else passed++;
        sb_q.delete();
        cyc();
        rst_ni = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_limit();
        test_errors();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
